// File: rtl/mp_pkg.sv
// Shared constants and types for the multi-precision modular adder controller.
package mp_pkg;

  localparam int unsigned MP_WIDTH = 1027;

  typedef enum logic [2:0] {
    StIdle,
    StOp1Issue,
    StOp1Wait,
    StOp2Issue,
    StOp2Wait,
    StFinish
  } mp_modadd_state_t;

endpackage

// File: rtl/mp_timeout_cnt.sv
// Wait-cycle counter; expired flags the MAX_COUNT-th consecutive enabled cycle.
module mp_timeout_cnt #(
  parameter int unsigned MAX_COUNT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] Last = 8'(MAX_COUNT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else if (clear) begin
      cnt_q <= 8'd0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired = enable && (cnt_q == Last);

endmodule

// File: rtl/mp_modadd_ctrl.sv
// Sequences an external multi-precision adder to form (A+B) mod M or (A-B) mod M.
// Optional adder timeout is compiled in with MP_MODADD_TIMEOUT_EN.
module mp_modadd_ctrl
  import mp_pkg::*;
#(
  parameter int unsigned WIDTH          = MP_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
`ifdef MP_MODADD_TIMEOUT_EN
  ,
  output logic             error
`endif
);

  mp_modadd_state_t state_q;

  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] res_q;
  logic             sub_q;
  logic             err_q;
  logic             in_wait;
  logic             timeout;

  assign in_wait = (state_q == StOp1Wait) || (state_q == StOp2Wait);

`ifdef MP_MODADD_TIMEOUT_EN
  mp_timeout_cnt #(
    .MAX_COUNT(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(timeout)
  );

  assign error = err_q;
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign unused_cfg = ^{TIMEOUT_CYCLES, err_q, in_wait};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      result       <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
      m_q          <= '0;
      r1_q         <= '0;
      res_q        <= '0;
      sub_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done      <= 1'b0;
      add_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            // A and B live only in the adder operand registers until OP1 completes.
            add_a        <= in_a;
            add_b        <= in_b;
            add_subtract <= subtract;
            add_start    <= 1'b1;
            m_q          <= in_m;
            sub_q        <= subtract;
            busy         <= 1'b1;
            err_q        <= 1'b0;
            state_q      <= StOp1Issue;
          end
        end
        StOp1Issue: state_q <= StOp1Wait;
        StOp1Wait: begin
          if (add_done) begin
            r1_q <= add_result[WIDTH-1:0];
            if (!sub_q || add_result[WIDTH]) begin
              // Add mode always subtracts M; a negative difference gets M added back.
              add_a        <= add_result[WIDTH-1:0];
              add_b        <= m_q;
              add_subtract <= !sub_q;
              add_start    <= 1'b1;
              state_q      <= StOp2Issue;
            end else begin
              res_q   <= add_result[WIDTH-1:0];
              state_q <= StFinish;
            end
          end else if (timeout) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            state_q <= StFinish;
          end
        end
        StOp2Issue: state_q <= StOp2Wait;
        StOp2Wait: begin
          if (add_done) begin
            if (!sub_q && add_result[WIDTH]) begin
              res_q <= r1_q;
            end else begin
              res_q <= add_result[WIDTH-1:0];
            end
            state_q <= StFinish;
          end else if (timeout) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            state_q <= StFinish;
          end
        end
        StFinish: begin
          result  <= res_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_modadd_ctrl.sv
// Directed bench for mp_modadd_ctrl with a 2-cycle behavioural adder model.
module tb_mp_modadd_ctrl;

  localparam int unsigned W = 1027;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         subtract = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] in_m = '0;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic         add_start;
  logic         add_subtract;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W:0]   add_result = '0;
  logic         add_done;
`ifdef MP_MODADD_TIMEOUT_EN
  logic         error;
`endif

  logic         s1_v = 1'b0;
  logic [W:0]   s1_r = '0;
  logic         add_done_m = 1'b0;
  logic         model_en = 1'b1;
  logic         inj_done = 1'b0;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mp_modadd_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .subtract    (subtract),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_m        (in_m),
    .result      (result),
    .done        (done),
    .busy        (busy),
    .add_start   (add_start),
    .add_subtract(add_subtract),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_result  (add_result),
    .add_done    (add_done)
`ifdef MP_MODADD_TIMEOUT_EN
    ,
    .error       (error)
`endif
  );

  // Adder model: operands captured on add_start, result and done two cycles later.
  always @(posedge clk) begin
    s1_v <= add_start & model_en;
    if (add_start) begin
      s1_r <= add_subtract ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
    end
    add_done_m <= s1_v;
    add_result <= s1_r;
  end

  assign add_done = add_done_m | inj_done;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; returns in the cycle after done so the next call is back-to-back.
  task automatic run(input string tag, input int a, input int b, input int m, input logic sub,
                     input logic interfere, input int exp_res, input int exp_lat);
    int lat;
    in_a = W'(a);
    in_b = W'(b);
    in_m = W'(m);
    subtract = sub;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    check_bit({tag, "_busy"}, busy, 1'b1);
    check_bit({tag, "_add_start"}, add_start, 1'b1);
    check_val({tag, "_add_a"}, add_a, W'(a));
    check_val({tag, "_add_b"}, add_b, W'(b));
    check_bit({tag, "_add_sub"}, add_subtract, sub);
    while (!done && lat < 40) begin
      if (interfere && lat == 2) begin
        in_a = W'(1);
        in_b = W'(1);
        in_m = W'(5);
        subtract = ~sub;
        start = 1'b1;
      end
      step();
      start = 1'b0;
      lat++;
    end
    check_bit({tag, "_done"}, done, 1'b1);
    check_bit({tag, "_busy_at_done"}, busy, 1'b0);
    check_val({tag, "_result"}, result, W'(exp_res));
    check_int({tag, "_latency"}, lat, exp_lat);
    step();
    check_bit({tag, "_done_one_cycle"}, done, 1'b0);
    check_val({tag, "_result_hold"}, result, W'(exp_res));
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    check_val("rst_result", result, '0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_add_start", add_start, 1'b0);
    check_bit("rst_add_sub", add_subtract, 1'b0);
    check_val("rst_add_a", add_a, '0);
    check_val("rst_add_b", add_b, '0);
`ifdef MP_MODADD_TIMEOUT_EN
    check_bit("rst_error", error, 1'b0);
`endif

    // Stray adder completion while idle must be ignored.
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    check_bit("stray_busy", busy, 1'b0);
    step();
    check_bit("stray_done", done, 1'b0);

    run("add_wrap", 7, 9, 13, 1'b0, 1'b0, 3, 8);
    run("add_nowrap", 5, 4, 13, 1'b0, 1'b0, 9, 8);
    run("sub_neg", 3, 9, 13, 1'b1, 1'b0, 7, 8);
    run("sub_pos", 9, 3, 13, 1'b1, 1'b0, 6, 5);
    run("start_while_busy", 7, 9, 13, 1'b0, 1'b1, 3, 8);

    // Reset while OP2 is in flight.
    in_a = W'(7);
    in_b = W'(9);
    in_m = W'(13);
    subtract = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check_bit("mid_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check_bit("abort_busy", busy, 1'b0);
    check_val("abort_result", result, '0);
    step();
    reset = 1'b0;
    check_bit("abort_no_done", done, 1'b0);
    run("after_reset", 9, 3, 13, 1'b1, 1'b0, 6, 5);

`ifdef MP_MODADD_TIMEOUT_EN
    model_en = 1'b0;
    run("timeout", 7, 9, 13, 1'b0, 1'b0, 0, 19);
    check_bit("timeout_error", error, 1'b1);
    model_en = 1'b1;
    in_a = W'(7);
    in_b = W'(9);
    in_m = W'(13);
    subtract = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_bit("error_cleared", error, 1'b0);
    repeat (10) step();
    check_val("post_timeout_result", result, W'(3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mp_modadd_ctrl.md
MP_MODADD_CTRL -- requirements
Module: mp_modadd_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1027, giving the operand and modulus width in bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum adder wait in cycles; it is used only with the timeout feature.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  clock, rising edge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 start  in  1  one-cycle request; ignored unless idle.
REQ-006 subtract  in  1  0: (A+B) mod M; 1: (A-B) mod M.
REQ-007 in_a, in_b, in_m  in  WIDTH each  operands and modulus; sampled on an accepted start; the operands satisfy A,B < M.
REQ-008 result  out  WIDTH  modular result.
REQ-009 done  out  1  one-cycle pulse; result is valid from this cycle.
REQ-010 busy  out  1  high from the accepted start until done.
REQ-011 add_start  out  1  one-cycle pulse to the multi-precision adder.
REQ-012 add_subtract  out  1  adder mode, held constant while the adder operation is in flight.
REQ-013 add_a, add_b  out  WIDTH each  adder operands, held constant while the adder operation is in flight.
REQ-014 add_result  in  WIDTH+1  adder sum; when add_subtract=1, bit WIDTH=1 means the difference is negative.
REQ-015 add_done  in  1  adder completion pulse.
REQ-016 error  out  1  adder timeout flag; the port exists only when the timeout feature is compiled in.

Function
REQ-017 The FSM SHALL have the states IDLE, OP1_ISSUE, OP1_WAIT, OP2_ISSUE, OP2_WAIT and FINISH.
REQ-018 In IDLE, a start SHALL latch in_a, in_b, in_m and subtract, then move to OP1_ISSUE.
REQ-019 OP1_ISSUE SHALL drive add_a=A, add_b=B and add_subtract=subtract, pulse add_start for one cycle, then move to OP1_WAIT.
REQ-020 OP1_WAIT SHALL hold until add_done and SHALL latch R1=add_result on that cycle.
REQ-021 In add mode, the block SHALL then always issue a second operation, R2=R1-M (add_a=R1[WIDTH-1:0], add_b=M, add_subtract=1).
REQ-022 In add mode, the final result SHALL be R2 if R2[WIDTH]=0, else R1.
REQ-023 In subtract mode with R1[WIDTH]=0, the block SHALL skip OP2 and go directly to FINISH with result=R1[WIDTH-1:0].
REQ-024 In subtract mode with R1[WIDTH]=1, the block SHALL issue R2=R1+M (add_subtract=0) and SHALL use result=R2[WIDTH-1:0].
REQ-025 FINISH SHALL register result, pulse done for one cycle and return to IDLE.
REQ-026 The block SHALL accept back-to-back starts: a start in the cycle after done is accepted.
REQ-027 A start while busy SHALL be ignored and SHALL NOT alter the latched operands.
REQ-028 An add_done outside OP1_WAIT or OP2_WAIT SHALL be ignored.
REQ-029 Latency SHALL be 2 + adder latency + 1 cycles with one adder operation, and that plus (1 + adder latency) with two.
REQ-030 result SHALL hold its value until the next FINISH.

Reset
REQ-031 On reset the block SHALL go to state IDLE with result=0, done=0, busy=0, add_start=0, add_subtract=0, add_a=0, add_b=0 and error=0.
REQ-032 A reset mid-operation SHALL abort with no done pulse, and the block SHALL accept a new start in the first cycle after reset deasserts.

Configuration
REQ-033 The macro MP_MODADD_TIMEOUT_EN SHALL control the timeout feature.
REQ-034 When MP_MODADD_TIMEOUT_EN is defined, an 8-bit counter SHALL count cycles in each WAIT state; on reaching TIMEOUT_CYCLES without add_done, the block SHALL go to FINISH with result=0 and error=1.
REQ-035 error SHALL clear on the next accepted start.
REQ-036 When MP_MODADD_TIMEOUT_EN is undefined, the block SHALL have no counter and no error port, and SHALL wait for add_done indefinitely.

Structure
REQ-037 The shared package mp_pkg SHALL hold the WIDTH default constant and the state enum typedef (mp_modadd_state_t).
REQ-038 The timeout counter SHALL be the one sub-module, mp_timeout_cnt (inputs clear and enable; output expired), instantiated only under MP_MODADD_TIMEOUT_EN.

Verification
REQ-039 The bench SHALL drive the adder ports from a behavioural adder model with 2-cycle latency, and SHALL cover these directed scenarios:
REQ-040 M=13, A=7, B=9, add -> two adder ops, result=3, done one cycle.
REQ-041 M=13, A=5, B=4, add -> R2 negative, result=9.
REQ-042 M=13, A=3, B=9, subtract -> R1 negative, second op R1+M, result=7; M=13, A=9, B=3, subtract -> single op, result=6, done 3 cycles earlier.
REQ-043 start pulsed in OP1_WAIT with different operands -> ignored, result as for the first request; reset asserted in OP2_WAIT -> busy=0, no done, next request correct.
REQ-044 With MP_MODADD_TIMEOUT_EN defined and add_done never asserted -> done and error=1 after 16 wait cycles, result=0; the next start clears error.
